decryption_out_packer: RTL and testbench

Downstream stage of the decryption top level. Takes the 8-bit decrypted character stream (`data_o`/`valid_o` of the decryption top, after the output mux) and packs it into 32-bit words, least-significant byte first. Words are buffered in a small word FIFO and presented on a 32-bit valid/ready master interface. A terminator character closes a message, flushing any partial word tagged with its byte count and a last flag.

---
 rtl/decryption_out_packer.sv | 120 ++++++++++++
 tb/tb_decryption_out_packer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/decryption_out_packer.sv
// Packs the decrypted 8-bit character stream into 32-bit words (LSB first) and buffers them
// in a small word FIFO behind a valid/ready master port; a terminator flushes the partial word.
module decryption_out_packer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  TERM_CHAR  = 8'hFA
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        last_o,
  output logic [2:0]  bytes_o,
  output logic        busy_o,
  output logic        overflow_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [PtrW:0] CntBusy = (PtrW + 1)'(FIFO_DEPTH - 1);

  logic [31:0]     pack_q, pack_d;
  logic [1:0]      k_q, k_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;

  logic [31:0] mem_data_q  [FIFO_DEPTH];
  logic [2:0]  mem_bytes_q [FIFO_DEPTH];
  logic        mem_last_q  [FIFO_DEPTH];

  logic        is_term, full, pop, push_req, push;
  logic [31:0] push_data;
  logic [2:0]  push_bytes;
  logic        push_last;

  assign valid_o    = (cnt_q != '0);
  assign data_o     = valid_o ? mem_data_q[rd_ptr_q]  : '0;
  assign bytes_o    = valid_o ? mem_bytes_q[rd_ptr_q] : '0;
  assign last_o     = valid_o ? mem_last_q[rd_ptr_q]  : 1'b0;
  assign busy_o     = busy_q;
  assign overflow_o = ovf_q;

  always_comb begin
    is_term  = (data_i == TERM_CHAR);
    full     = (cnt_q == CntFull);
    pop      = valid_o && ready_i;
    push_req = valid_i && (is_term || (k_q == 2'd3));
    // A simultaneous pop frees the slot, so a full FIFO can still accept the push.
    push     = push_req && (!full || pop);

    pack_d     = pack_q;
    k_d        = k_q;
    push_data  = pack_q;
    push_bytes = {1'b0, k_q};
    push_last  = 1'b1;

    if (valid_i) begin
      if (is_term) begin
        pack_d = '0;
        k_d    = '0;
      end else if (k_q == 2'd3) begin
        push_data  = {data_i, pack_q[23:0]};
        push_bytes = 3'd4;
        push_last  = 1'b0;
        pack_d     = '0;
        k_d        = '0;
      end else begin
        pack_d = pack_q | ({24'd0, data_i} << {k_q, 3'b000});
        k_d    = k_q + 2'd1;
      end
    end

    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PtrW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (PtrW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase

    busy_d = (cnt_d >= CntBusy);
    ovf_d  = ovf_q | (push_req && !push);
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      pack_q   <= '0;
      k_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      pack_q   <= pack_d;
      k_q      <= k_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_sys) begin
    if (push && !rst) begin
      mem_data_q[wr_ptr_q]  <= push_data;
      mem_bytes_q[wr_ptr_q] <= push_bytes;
      mem_last_q[wr_ptr_q]  <= push_last;
    end
  end

endmodule

// File: tb/tb_decryption_out_packer.sv
// Directed bench for decryption_out_packer: vector table for the basic packing cases plus
// hand-written sequences for full/overflow, push+pop at full, stalls and mid-stream reset.
module tb_decryption_out_packer;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        last_o;
  logic [2:0]  bytes_o;
  logic        busy_o;
  logic        overflow_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  decryption_out_packer #(
    .FIFO_DEPTH (4),
    .TERM_CHAR  (8'hFA)
  ) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .last_o     (last_o),
    .bytes_o    (bytes_o),
    .busy_o     (busy_o),
    .overflow_o (overflow_o)
  );

  typedef struct packed {
    logic        v;
    logic [7:0]  d;
    logic        r;
    logic        ev;
    logic [31:0] ed;
    logic [2:0]  eb;
    logic        el;
    logic        ebusy;
    logic        eovf;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [38:0] outs();
    return {valid_o, data_o, bytes_o, last_o, busy_o, overflow_o};
  endfunction

  function automatic logic [31:0] w4(input logic [7:0] b0);
    return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle; return #1 after the active edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0]  d;
    logic        v, r, stall;
    logic [35:0] prev, exp_w;
    int          sent, got;

    rst = 1'b1;
    valid_i = 1'b0;
    data_i = 8'h00;
    ready_i = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    chk("reset_outputs", 64'(outs()), 64'd0);

    // {v, d, r, exp valid, data, bytes, last, busy, ovf} observed after the edge
    tbl[0] = '{1'b1, 8'h41, 1'b1, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h42, 1'b1, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h43, 1'b1, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h44, 1'b1, 1'b1, 32'h44434241, 3'd4, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h61, 1'b1, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 8'h62, 1'b1, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 8'hFA, 1'b1, 1'b1, 32'h00006261, 3'd2, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 8'hFA, 1'b1, 1'b1, 32'h0,        3'd0, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("vec%0d", i), 64'(outs()),
          64'({tbl[i].ev, tbl[i].ed, tbl[i].eb, tbl[i].el, tbl[i].ebusy, tbl[i].eovf}));
    end

    // Five words into a stalled FIFO: four held, fifth dropped.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'h10 + 8'(i), 1'b0);
      if (i == 7)  chk("busy_after_2w", 64'(busy_o), 64'd0);
      if (i == 11) chk("busy_after_3w", 64'(busy_o), 64'd1);
      if (i == 15) chk("ovf_after_4w", 64'(overflow_o), 64'd0);
    end
    chk("ovf_after_5w", 64'(overflow_o), 64'd1);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("drain%0d", j), 64'({valid_o, data_o, bytes_o, last_o}),
          64'({1'b1, w4(8'h10 + 8'(4 * j)), 3'd4, 1'b0}));
      cyc(1'b0, 8'h00, 1'b1);
    end
    chk("drain_empty", 64'(valid_o), 64'd0);
    chk("ovf_sticky", 64'(overflow_o), 64'd1);

    // Push and pop in the same cycle with the FIFO full.
    do_reset();
    for (int i = 0; i < 19; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0);
    cyc(1'b1, 8'h43, 1'b1);
    chk("fullpp_head", 64'({valid_o, data_o}), 64'({1'b1, w4(8'h34)}));
    chk("fullpp_ovf", 64'(overflow_o), 64'd0);
    chk("fullpp_busy", 64'(busy_o), 64'd1);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("fullpp_drain%0d", j), 64'({valid_o, data_o}),
          64'({1'b1, w4(8'h34 + 8'(4 * j))}));
      cyc(1'b0, 8'h00, 1'b1);
    end
    chk("fullpp_empty", 64'(valid_o), 64'd0);

    // 40-byte message plus terminator with random backpressure.
    do_reset();
    sent = 0;
    got = 0;
    stall = 1'b0;
    prev = '0;
    for (int c = 0; c < 400 && got < 11; c++) begin
      if (stall) chk("stall_stable", 64'({valid_o, data_o, bytes_o}), 64'(prev));
      r = 1'($urandom_range(0, 1));
      if (valid_o && r) begin
        exp_w = (got < 10) ? {w4(8'h50 + 8'(4 * got)), 3'd4, 1'b0} : {32'd0, 3'd0, 1'b1};
        chk($sformatf("msg_word%0d", got), 64'({data_o, bytes_o, last_o}), 64'(exp_w));
        got++;
      end
      stall = valid_o && !r;
      prev = {valid_o, data_o, bytes_o};
      if (sent < 41) begin
        v = 1'b1;
        d = (sent < 40) ? 8'h50 + 8'(sent) : 8'hFA;
        sent++;
      end else begin
        v = 1'b0;
        d = 8'h00;
      end
      cyc(v, d, r);
    end
    chk("msg_word_count", 64'(got), 64'd11);
    chk("msg_no_ovf", 64'(overflow_o), 64'd0);

    // Reset with two words buffered and a partial pack.
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0);
    rst = 1'b1;
    cyc(1'b1, 8'h99, 1'b0);
    rst = 1'b0;
    chk("midrst_outputs", 64'(outs()), 64'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'hA1 + 8'(i), 1'b1);
    chk("midrst_fresh", 64'({valid_o, data_o, bytes_o, last_o}),
        64'({1'b1, 32'hA4A3A2A1, 3'd4, 1'b0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
